// File: rtl/vtg_pkg.sv
// Shared types and defaults for the raster timing generator: per-axis timing
// description, default arcade timing and a small clamp helper.
package vtg_pkg;

    typedef struct packed {
        int blk_end;
        int blk_start;
        int s_start;
        int s_end;
        int jump_from;
        int jump_to;
        int last;
    } axis_cfg_t;

    localparam int DEF_CW          = 9;
    localparam int DEF_RGB_W       = 12;
    localparam int DEF_POS_OFS     = 16;

    localparam int DEF_H_BLK_END   = 15;
    localparam int DEF_H_BLK_START = 272;
    localparam int DEF_HS_START    = 311;
    localparam int DEF_HS_END      = 342;
    localparam int DEF_H_JUMP_FROM = 342;
    localparam int DEF_H_JUMP_TO   = 471;
    localparam int DEF_H_LAST      = 511;

    localparam int DEF_V_BLK_END   = 15;
    localparam int DEF_V_BLK_START = 207;
    localparam int DEF_VS_START    = 235;
    localparam int DEF_VS_END      = 242;
    localparam int DEF_V_JUMP_FROM = 242;
    localparam int DEF_V_JUMP_TO   = 492;
    localparam int DEF_V_LAST      = 511;

    localparam axis_cfg_t H_DEFAULT = '{
        blk_end:   DEF_H_BLK_END,
        blk_start: DEF_H_BLK_START,
        s_start:   DEF_HS_START,
        s_end:     DEF_HS_END,
        jump_from: DEF_H_JUMP_FROM,
        jump_to:   DEF_H_JUMP_TO,
        last:      DEF_H_LAST
    };

    function automatic int clamp(input int value, input int lo, input int hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/vtg_axis.sv
// One raster axis: position counter with jump and wrap, plus blank and sync
// flags, all advancing only when 'advance' is high.
module vtg_axis
    import vtg_pkg::*;
#(
    parameter int        CW  = DEF_CW,
    parameter axis_cfg_t CFG = H_DEFAULT
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          advance,
    input  logic [CW-1:0] s_start,
    input  logic [CW-1:0] s_end,
    output logic [CW-1:0] cnt,
    output logic          blank,
    output logic          sync_n,
    output logic          wrap
);

    localparam logic [CW-1:0] BLK_END   = CW'(CFG.blk_end);
    localparam logic [CW-1:0] BLK_START = CW'(CFG.blk_start);
    localparam logic [CW-1:0] JUMP_FROM = CW'(CFG.jump_from);
    localparam logic [CW-1:0] JUMP_TO   = CW'(CFG.jump_to);
    localparam logic [CW-1:0] LAST      = CW'(CFG.last);

    logic [CW-1:0] cnt_next;

    // Wrapping at LAST takes priority over the jump.
    always_comb begin
        cnt_next = cnt + CW'(1);
        if (cnt == LAST) begin
            cnt_next = '0;
        end else if (cnt == JUMP_FROM) begin
            cnt_next = JUMP_TO;
        end
    end

    assign wrap = advance && (cnt == LAST);

    // Flags react to the position being left, so they change one step later.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            blank  <= 1'b1;
            sync_n <= 1'b1;
        end else if (advance) begin
            cnt <= cnt_next;
            if (cnt == BLK_END) begin
                blank <= 1'b0;
            end else if (cnt == BLK_START) begin
                blank <= 1'b1;
            end
            if (cnt == s_start) begin
                sync_n <= 1'b0;
            end else if (cnt == s_end) begin
                sync_n <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised arcade raster timing generator with blanked RGB register stage.
// Define VTG_SHIFT_EN to allow runtime hsync/vsync shifting, latched per frame.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int CW          = DEF_CW,
    parameter int RGB_W       = DEF_RGB_W,
    parameter int H_BLK_END   = DEF_H_BLK_END,
    parameter int H_BLK_START = DEF_H_BLK_START,
    parameter int HS_START    = DEF_HS_START,
    parameter int HS_END      = DEF_HS_END,
    parameter int H_JUMP_FROM = DEF_H_JUMP_FROM,
    parameter int H_JUMP_TO   = DEF_H_JUMP_TO,
    parameter int H_LAST      = DEF_H_LAST,
    parameter int V_BLK_END   = DEF_V_BLK_END,
    parameter int V_BLK_START = DEF_V_BLK_START,
    parameter int VS_START    = DEF_VS_START,
    parameter int VS_END      = DEF_VS_END,
    parameter int V_JUMP_FROM = DEF_V_JUMP_FROM,
    parameter int V_JUMP_TO   = DEF_V_JUMP_TO,
    parameter int V_LAST      = DEF_V_LAST,
    parameter int POS_OFS     = DEF_POS_OFS
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ce_pix,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic [3:0]       h_shift,
    input  logic [3:0]       v_shift,
    output logic [CW-1:0]    hpos,
    output logic [CW-1:0]    vpos,
    output logic [RGB_W-1:0] rgb_out,
    output logic             hblank,
    output logic             vblank,
    output logic             hs_n,
    output logic             vs_n,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
);

    localparam axis_cfg_t H_CFG = '{
        blk_end: H_BLK_END, blk_start: H_BLK_START, s_start: HS_START, s_end: HS_END,
        jump_from: H_JUMP_FROM, jump_to: H_JUMP_TO, last: H_LAST
    };
    localparam axis_cfg_t V_CFG = '{
        blk_end: V_BLK_END, blk_start: V_BLK_START, s_start: VS_START, s_end: VS_END,
        jump_from: V_JUMP_FROM, jump_to: V_JUMP_TO, last: V_LAST
    };
    localparam logic [CW-1:0] POS_OFS_C = CW'(POS_OFS);

    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          h_wrap;
    logic          v_wrap;
    logic [CW-1:0] hs_start_eff;
    logic [CW-1:0] hs_end_eff;
    logic [CW-1:0] vs_start_eff;
    logic [CW-1:0] vs_end_eff;

`ifdef VTG_SHIFT_EN
    logic [3:0] h_shift_q;
    logic [3:0] v_shift_q;
    int         hs_start_i;
    int         hs_end_i;
    int         vs_start_i;
    int         vs_end_i;

    // Shifts only take effect at a frame boundary so a frame never tears.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            h_shift_q <= '0;
            v_shift_q <= '0;
        end else if (v_wrap) begin
            h_shift_q <= h_shift;
            v_shift_q <= v_shift;
        end
    end

    always_comb begin
        hs_start_i = clamp(HS_START + int'($signed(h_shift_q)), H_BLK_START + 1, H_JUMP_FROM - 1);
        hs_end_i   = clamp(HS_END + int'($signed(h_shift_q)), hs_start_i + 1, H_JUMP_FROM);
        vs_start_i = clamp(VS_START + int'($signed(v_shift_q)), V_BLK_START + 1, V_JUMP_FROM - 1);
        vs_end_i   = clamp(VS_END + int'($signed(v_shift_q)), vs_start_i + 1, V_JUMP_FROM);
    end

    assign hs_start_eff = CW'(hs_start_i);
    assign hs_end_eff   = CW'(hs_end_i);
    assign vs_start_eff = CW'(vs_start_i);
    assign vs_end_eff   = CW'(vs_end_i);
`else
    logic unused_shift;

    assign unused_shift = ^{h_shift, v_shift};
    assign hs_start_eff = CW'(HS_START);
    assign hs_end_eff   = CW'(HS_END);
    assign vs_start_eff = CW'(VS_START);
    assign vs_end_eff   = CW'(VS_END);
`endif

    vtg_axis #(
        .CW  (CW),
        .CFG (H_CFG)
    ) u_h_axis (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .advance (ce_pix),
        .s_start (hs_start_eff),
        .s_end   (hs_end_eff),
        .cnt     (hcnt),
        .blank   (hblank),
        .sync_n  (hs_n),
        .wrap    (h_wrap)
    );

    vtg_axis #(
        .CW  (CW),
        .CFG (V_CFG)
    ) u_v_axis (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .advance (h_wrap),
        .s_start (vs_start_eff),
        .s_end   (vs_end_eff),
        .cnt     (vcnt),
        .blank   (vblank),
        .sync_n  (vs_n),
        .wrap    (v_wrap)
    );

    assign hpos = hcnt - POS_OFS_C;
    assign vpos = vcnt - POS_OFS_C;

    // Strobes last one clk_sys; pixel data uses the flags of the pixel being shown.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out     <= '0;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            if (ce_pix) begin
                rgb_out <= (hblank || vblank) ? '0 : rgb_in;
                de      <= !(hblank || vblank);
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: default horizontal timing, shortened
// vertical timing (13 lines/frame) so several frames fit in a short run.
`timescale 1ns/1ps
module tb_video_timing_gen;

    localparam int CW          = 9;
    localparam int RGB_W       = 12;
    localparam int H_BLK_END   = 15;
    localparam int H_BLK_START = 272;
    localparam int HS_START    = 311;
    localparam int HS_END      = 342;
    localparam int H_JUMP_FROM = 342;
    localparam int H_JUMP_TO   = 471;
    localparam int H_LAST      = 511;
    localparam int V_BLK_END   = 2;
    localparam int V_BLK_START = 5;
    localparam int VS_START    = 7;
    localparam int VS_END      = 9;
    localparam int V_JUMP_FROM = 9;
    localparam int V_JUMP_TO   = 13;
    localparam int V_LAST      = 15;
    localparam int POS_OFS     = 16;
    localparam int LINE_CE     = 384;
    localparam int FRAME_CE    = LINE_CE * 13;

    typedef struct {
        int hpos;
        int vpos;
        bit hb;
        bit vb;
        bit hsn;
        bit vsn;
        bit de;
        bit ls;
        bit fs;
        int rgb;
    } exp_t;

    exp_t sb_q[$];

    logic             clk_sys = 1'b0;
    logic             reset_n = 1'b0;
    logic             ce_pix  = 1'b0;
    logic [RGB_W-1:0] rgb_in  = '0;
    logic [3:0]       h_shift = '0;
    logic [3:0]       v_shift = '0;
    logic [CW-1:0]    hpos;
    logic [CW-1:0]    vpos;
    logic [RGB_W-1:0] rgb_out;
    logic             hblank;
    logic             vblank;
    logic             hs_n;
    logic             vs_n;
    logic             de;
    logic             line_start;
    logic             frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: position the DUT will hold after the pending edge.
    int m_h   = 0;
    int m_v   = 0;
    int m_hsh = 0;
    int m_vsh = 0;
    bit m_de  = 1'b0;
    int m_rgb = 0;

    video_timing_gen #(
        .CW(CW), .RGB_W(RGB_W),
        .H_BLK_END(H_BLK_END), .H_BLK_START(H_BLK_START), .HS_START(HS_START), .HS_END(HS_END),
        .H_JUMP_FROM(H_JUMP_FROM), .H_JUMP_TO(H_JUMP_TO), .H_LAST(H_LAST),
        .V_BLK_END(V_BLK_END), .V_BLK_START(V_BLK_START), .VS_START(VS_START), .VS_END(VS_END),
        .V_JUMP_FROM(V_JUMP_FROM), .V_JUMP_TO(V_JUMP_TO), .V_LAST(V_LAST),
        .POS_OFS(POS_OFS)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ce_pix      (ce_pix),
        .rgb_in      (rgb_in),
        .h_shift     (h_shift),
        .v_shift     (v_shift),
        .hpos        (hpos),
        .vpos        (vpos),
        .rgb_out     (rgb_out),
        .hblank      (hblank),
        .vblank      (vblank),
        .hs_n        (hs_n),
        .vs_n        (vs_n),
        .de          (de),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic int clampi(input int x, input int lo, input int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    function automatic bit in_range(input int x, input int lo, input int hi);
        return (x >= lo) && (x <= hi);
    endfunction

    // Blank/sync levels follow from the position alone: a flag changes when
    // its trigger position is left, so the active window starts one past it.
    function automatic exp_t model_outputs();
        exp_t e;
        int   hs_s;
        int   hs_e;
        int   vs_s;
        int   vs_e;
        hs_s  = clampi(HS_START + m_hsh, H_BLK_START + 1, H_JUMP_FROM - 1);
        hs_e  = clampi(HS_END + m_hsh, hs_s + 1, H_JUMP_FROM);
        vs_s  = clampi(VS_START + m_vsh, V_BLK_START + 1, V_JUMP_FROM - 1);
        vs_e  = clampi(VS_END + m_vsh, vs_s + 1, V_JUMP_FROM);
        e.hpos = (m_h - POS_OFS) & ((1 << CW) - 1);
        e.vpos = (m_v - POS_OFS) & ((1 << CW) - 1);
        e.hb   = !in_range(m_h, H_BLK_END + 1, H_BLK_START);
        e.vb   = !in_range(m_v, V_BLK_END + 1, V_BLK_START);
        e.hsn  = !in_range(m_h, hs_s + 1, hs_e);
        e.vsn  = !in_range(m_v, vs_s + 1, vs_e);
        e.de   = m_de;
        e.rgb  = m_rgb;
        e.ls   = 1'b0;
        e.fs   = 1'b0;
        return e;
    endfunction

    function automatic int s4(input logic [3:0] x);
        return int'($signed(x));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t, model h=%0d v=%0d)",
                     name, act, req, $time, m_h, m_v);
        end
    endtask

    // Drive one clk_sys cycle of inputs and queue the state expected after the edge.
    task automatic applyStimulus(input bit rst_n_v, input bit ce, input logic [RGB_W-1:0] rgb);
        exp_t e;
        bit   blank_now;
        bit   ls;
        bit   fs;
        @(negedge clk_sys);
        reset_n = rst_n_v;
        ce_pix  = ce;
        rgb_in  = rgb;
        ls = 1'b0;
        fs = 1'b0;
        if (!rst_n_v) begin
            m_h = 0; m_v = 0; m_hsh = 0; m_vsh = 0; m_de = 1'b0; m_rgb = 0;
        end else if (ce) begin
            blank_now = !in_range(m_h, H_BLK_END + 1, H_BLK_START) ||
                        !in_range(m_v, V_BLK_END + 1, V_BLK_START);
            m_rgb = blank_now ? 0 : int'(rgb);
            m_de  = !blank_now;
            if (m_h == H_LAST) begin
                m_h = 0;
                ls  = 1'b1;
                if (m_v == V_LAST) begin
                    m_v = 0;
                    fs  = 1'b1;
`ifdef VTG_SHIFT_EN
                    m_hsh = s4(h_shift);
                    m_vsh = s4(v_shift);
`endif
                end else begin
                    m_v = (m_v == V_JUMP_FROM) ? V_JUMP_TO : m_v + 1;
                end
            end else begin
                m_h = (m_h == H_JUMP_FROM) ? H_JUMP_TO : m_h + 1;
            end
        end
        e    = model_outputs();
        e.ls = ls;
        e.fs = fs;
        sb_q.push_back(e);
    endtask

    // Immediate check that an asynchronous reset has already taken effect.
    task automatic checkResetNow();
        #1;
        checkOutput("async_rst_hpos", 32'(hpos), 32'(496));
        checkOutput("async_rst_vpos", 32'(vpos), 32'(496));
        checkOutput("async_rst_hblank", 32'(hblank), 32'd1);
        checkOutput("async_rst_vblank", 32'(vblank), 32'd1);
        checkOutput("async_rst_hs_n", 32'(hs_n), 32'd1);
        checkOutput("async_rst_vs_n", 32'(vs_n), 32'd1);
        checkOutput("async_rst_rgb", 32'(rgb_out), 32'd0);
        checkOutput("async_rst_de", 32'(de), 32'd0);
        checkOutput("async_rst_ls", 32'(line_start), 32'd0);
        checkOutput("async_rst_fs", 32'(frame_start), 32'd0);
    endtask

    // Monitor: every clk_sys edge with a queued expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_sys);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("hpos", 32'(hpos), 32'(e.hpos));
                checkOutput("vpos", 32'(vpos), 32'(e.vpos));
                checkOutput("hblank", 32'(hblank), 32'(e.hb));
                checkOutput("vblank", 32'(vblank), 32'(e.vb));
                checkOutput("hs_n", 32'(hs_n), 32'(e.hsn));
                checkOutput("vs_n", 32'(vs_n), 32'(e.vsn));
                checkOutput("de", 32'(de), 32'(e.de));
                checkOutput("rgb_out", 32'(rgb_out), 32'(e.rgb));
                checkOutput("line_start", 32'(line_start), 32'(e.ls));
                checkOutput("frame_start", 32'(frame_start), 32'(e.fs));
            end
        end
    end

    initial begin
        bit hit;
        $display("[TB] reset phase");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 12'hABC);

        $display("[TB] two frames, ce every cycle, constant pixel");
        for (int i = 0; i < 2 * FRAME_CE; i++) applyStimulus(1'b1, 1'b1, 12'hABC);

        $display("[TB] ce every 4th cycle, varying pixel");
        for (int i = 0; i < 800 * 4; i++) applyStimulus(1'b1, (i % 4) == 0, 12'(i * 37));

        $display("[TB] hsync shift +4 applied mid-frame");
        h_shift = 4'd4;
        for (int i = 0; i < 2 * FRAME_CE + FRAME_CE / 2; i++) applyStimulus(1'b1, 1'b1, 12'(i));

        $display("[TB] hsync shift -8");
        h_shift = 4'b1000;
        for (int i = 0; i < 2 * FRAME_CE; i++) applyStimulus(1'b1, 1'b1, 12'h3C5);

        $display("[TB] reset mid-frame at h=200 v=4");
        hit = 1'b0;
        for (int i = 0; i < FRAME_CE + 1 && !hit; i++) begin
            if (m_h == 200 && m_v == 4) hit = 1'b1;
            else applyStimulus(1'b1, 1'b1, 12'h5A5);
        end
        checkOutput("reached_h200_v4", 32'(hit), 32'd1);
        applyStimulus(1'b0, 1'b1, 12'h5A5);
        checkResetNow();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 12'h5A5);
        for (int i = 0; i < LINE_CE + 40; i++) applyStimulus(1'b1, 1'b1, 12'h5A5);

        @(posedge clk_sys);
        #2;
        checkOutput("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
